// File: rtl/nhan_cong_pkg.sv
// Shared types and constants for the nhan_cong sequential sum-of-products unit.
package nhan_cong_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N     = 2;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/nhan_cong_tuan_tu_if.sv
// Start/done request bus of the sequential dot-product unit: operands in, result and status out.
interface nhan_cong_tuan_tu_if
  import nhan_cong_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int P_W   = 2 * WIDTH + clog2(N) + 1
) ();

  logic               start;
  logic               clr_acc;
  logic [N*WIDTH-1:0] a_in;
  logic [N*WIDTH-1:0] b_in;
  logic               busy;
  logic               done;
  logic [P_W-1:0]     p;
  logic               ovf;

  modport master (
    output start, clr_acc, a_in, b_in,
    input  busy, done, p, ovf
  );

  modport slave (
    input  start, clr_acc, a_in, b_in,
    output busy, done, p, ovf
  );

endinterface

// File: rtl/nhan_cong_dp.sv
// Datapath: captured operands, one shift-add partial product and the shared accumulator.
module nhan_cong_dp
  import nhan_cong_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int P_W   = 2 * WIDTH + clog2(N) + 1,
  parameter int CW    = 1,
  parameter int BW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear_acc,
  input  logic               mul_step,
  input  logic               acc_step,
  input  logic [CW-1:0]      chan,
  input  logic [BW-1:0]      bit_idx,
  input  logic [N*WIDTH-1:0] a_in,
  input  logic [N*WIDTH-1:0] b_in,
  output logic [P_W-1:0]     acc_sum,
  output logic               carry
);

  logic [N-1:0][WIDTH-1:0] a_reg;
  logic [N-1:0][WIDTH-1:0] b_reg;
  logic [2*WIDTH-1:0]      partial;
  logic [P_W-1:0]          acc;
  logic [2*WIDTH-1:0]      shifted;
  logic [P_W:0]            acc_wide;

  assign shifted  = {{WIDTH{1'b0}}, a_reg[chan]} << bit_idx;
  assign acc_wide = {1'b0, acc} + {{(P_W + 1 - 2 * WIDTH){1'b0}}, partial};
  assign acc_sum  = acc_wide[P_W-1:0];
  assign carry    = acc_wide[P_W];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are cleared on reset as well; they are small and an aborted run must leave nothing behind.
      a_reg   <= '0;
      b_reg   <= '0;
      partial <= '0;
      acc     <= '0;
    end else begin
      if (load) begin
        a_reg   <= a_in;
        b_reg   <= b_in;
        partial <= '0;
      end else if (mul_step && b_reg[chan][bit_idx]) begin
        partial <= partial + shifted;
      end else if (acc_step) begin
        partial <= '0;
      end

      if (clear_acc)     acc <= '0;
      else if (acc_step) acc <= acc_sum;
    end
  end

endmodule

// File: rtl/nhan_cong_tuan_tu.sv
// Sequential sum-of-products P = sum A[k]*B[k] over one shared shift-add multiplier.
// Define NHAN_CONG_ACC_EN to accumulate across operations with clr_acc and a sticky ovf.
module nhan_cong_tuan_tu
  import nhan_cong_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int P_W   = 2 * WIDTH + clog2(N) + 1
) (
  input logic                clk,
  input logic                rst,
  nhan_cong_tuan_tu_if.slave bus
);

  localparam int CW = (N > 1) ? clog2(N) : 1;
  localparam int BW = clog2(WIDTH);

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  chan;
  logic [BW-1:0]  bit_idx;
  logic           last_bit;
  logic           last_chan;
  logic           busy;
  logic           done;
  logic           load;
  logic           clear_acc;
  logic           mul_step;
  logic           acc_step;
  logic [P_W-1:0] acc_sum;
  logic           carry;
  logic [P_W-1:0] p;
  logic           ovf;
  logic           unused_bits;

  assign last_bit  = (bit_idx == BW'(WIDTH - 1));
  assign last_chan = (chan == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = MUL;
      MUL:     if (last_bit) state_nx = ACC;
      ACC:     state_nx = last_chan ? DONE : MUL;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no latch is inferred.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    mul_step = 1'b0;
    acc_step = 1'b0;
    case (state)
      IDLE: load = bus.start;
      MUL: begin
        busy     = 1'b1;
        mul_step = 1'b1;
      end
      ACC: begin
        busy     = 1'b1;
        acc_step = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan    <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          chan    <= '0;
          bit_idx <= '0;
        end
        MUL: bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
        ACC: begin
          bit_idx <= '0;
          if (!last_chan) chan <= chan + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The result is taken from the adder output so it is already valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst)                        p <= '0;
    else if (acc_step && last_chan) p <= acc_sum;
  end

`ifdef NHAN_CONG_ACC_EN
  assign clear_acc = (state == IDLE) && bus.clr_acc;

  always_ff @(posedge clk) begin
    if (rst)                               ovf <= 1'b0;
    else if ((state == IDLE) && bus.clr_acc) ovf <= 1'b0;
    else if (acc_step && carry)            ovf <= 1'b1;
  end
`else
  assign clear_acc = load;
  assign ovf       = 1'b0;
`endif

  // clr_acc and carry have no effect unless accumulation is enabled.
  assign unused_bits = bus.clr_acc ^ carry;

  nhan_cong_dp #(
    .WIDTH (WIDTH),
    .N     (N),
    .P_W   (P_W),
    .CW    (CW),
    .BW    (BW)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .clear_acc (clear_acc),
    .mul_step  (mul_step),
    .acc_step  (acc_step),
    .chan      (chan),
    .bit_idx   (bit_idx),
    .a_in      (bus.a_in),
    .b_in      (bus.b_in),
    .acc_sum   (acc_sum),
    .carry     (carry)
  );

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.p    = p;
  assign bus.ovf  = ovf;

endmodule
